// File: rtl/prog_rom_seq_if.sv
// Bus bundle for the program ROM sequencer: fetch control, program-load
// port and the registered fetch/status outputs. The master side drives
// control and load signals; the slave side is the sequencer itself.
interface prog_rom_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              run;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              wrap;
  logic              write_err;

  modport master (
    output run, jump, jump_addr, prog_we, prog_addr, prog_data,
    input  instr, instr_addr, instr_valid, pc, halted, wrap, write_err
  );

  modport slave (
    input  run, jump, jump_addr, prog_we, prog_addr, prog_data,
    output instr, instr_addr, instr_valid, pc, halted, wrap, write_err
  );
endinterface

// File: rtl/prog_rom_seq.sv
// Program ROM sequencer: a small loadable instruction store fetched one
// word per cycle. The PC advances with wrap-around, can be redirected by a
// jump, and stops on a configurable halt word until the next jump.
module prog_rom_seq #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 4,
  parameter bit                 HALT_EN   = 1'b1,
  parameter logic [DATA_W-1:0]  HALT_WORD = '0
) (
  input  logic           clk,
  input  logic           reset,
  prog_rom_seq_if.slave  bus
);
  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_addr_q;
  logic              instr_valid_q;
  logic              wrap_q;
  logic              write_err_q;

  logic [DATA_W-1:0] rd_word;
  logic              fetch;
  logic              is_halt;
  logic              load_ok;

  assign rd_word = mem[pc_q];
  assign fetch   = (state == RUN) && bus.run;
  assign is_halt = HALT_EN && (rd_word == HALT_WORD);
  assign load_ok = bus.prog_we && !bus.run;

  // Program store: written only through the load port while fetch is idle.
  // NOTE: the store is cleared by reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (load_ok) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Sequencer FSM: fetch register, PC update, halt state and event pulses.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_addr_q  <= '0;
      instr_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      write_err_q   <= 1'b0;
    end else begin
      instr_valid_q <= fetch;
      wrap_q        <= 1'b0;
      write_err_q   <= bus.prog_we && bus.run;

      if (fetch) begin
        instr_q      <= rd_word;
        instr_addr_q <= pc_q;
      end

      if (bus.jump) begin
        pc_q  <= bus.jump_addr;
        state <= RUN;
      end else if (fetch) begin
        if (is_halt) begin
          state <= HALTED;
        end else begin
          pc_q   <= pc_q + 1'b1;
          wrap_q <= (pc_q == LAST);
        end
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = instr_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = (state == HALTED);
  assign bus.wrap        = wrap_q;
  assign bus.write_err   = write_err_q;
endmodule

// File: tb/tb_prog_rom_seq.sv
// Testbench for prog_rom_seq: directed program loads, runs, jumps, halts and
// resets. Each expected fetch is queued when issued; a negedge monitor pops
// and compares whenever instr_valid is seen.
module tb_prog_rom_seq;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  prog_rom_seq_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  prog_rom_seq #(.DATA_W(8), .ADDR_W(4), .HALT_EN(1'b1), .HALT_WORD(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic [3:0] addr;
    logic [3:0] pc;
    logic       wrap;
    logic       halted;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] i, input logic [3:0] a, input logic [3:0] p,
                      input logic w, input logic h);
    exp_t e;
    e.instr = i; e.addr = a; e.pc = p; e.wrap = w; e.halted = h;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic jump_to(input logic [3:0] a);
    bus.jump = 1'b1; bus.jump_addr = a;
    tick();
    bus.jump = 1'b0;
  endtask

  // Monitor: compare every presented fetch against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.instr_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got instr %0h at %0h, expected no fetch",
                 bus.instr, bus.instr_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("fetch_instr",  32'(bus.instr),      32'(e.instr));
        check("fetch_addr",   32'(bus.instr_addr), 32'(e.addr));
        check("fetch_pc",     32'(bus.pc),         32'(e.pc));
        check("fetch_wrap",   32'(bus.wrap),       32'(e.wrap));
        check("fetch_halted", 32'(bus.halted),     32'(e.halted));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.run = 1'b0; bus.jump = 1'b0; bus.jump_addr = '0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;

    // Reset state
    #3;
    check("rst_pc",          32'(bus.pc),          32'h0);
    check("rst_instr",       32'(bus.instr),       32'h0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_halted",      32'(bus.halted),      32'h0);
    check("rst_wrap",        32'(bus.wrap),        32'h0);
    check("rst_write_err",   32'(bus.write_err),   32'h0);
    reset = 1'b0;

    // Program image loaded with run=0
    load(4'd0, 8'h03); load(4'd1, 8'h1C); load(4'd2, 8'h4F); load(4'd3, 8'h2A);
    load(4'd4, 8'h77); load(4'd5, 8'h66); load(4'd6, 8'h55); load(4'd15, 8'h5F);
    check("load_no_fetch_pc", 32'(bus.pc), 32'h0);

    // Four sequential fetches
    push(8'h03, 4'd0, 4'd1, 1'b0, 1'b0);
    push(8'h1C, 4'd1, 4'd2, 1'b0, 1'b0);
    push(8'h4F, 4'd2, 4'd3, 1'b0, 1'b0);
    push(8'h2A, 4'd3, 4'd4, 1'b0, 1'b0);
    bus.run = 1'b1;
    repeat (4) tick();
    bus.run = 1'b0;
    check("seq_pc", 32'(bus.pc), 32'h4);
    tick();
    check("idle_valid", 32'(bus.instr_valid), 32'h0);
    check("idle_instr", 32'(bus.instr),       32'h2A);
    check("idle_pc",    32'(bus.pc),          32'h4);

    // Load attempt while running: error pulse, memory untouched
    push(8'h77, 4'd4, 4'd5, 1'b0, 1'b0);
    bus.run = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = 4'd1; bus.prog_data = 8'hFF;
    tick();
    bus.prog_we = 1'b0; bus.run = 1'b0;
    check("werr_pulse", 32'(bus.write_err), 32'h1);
    tick();
    check("werr_clear", 32'(bus.write_err), 32'h0);
    jump_to(4'd1);
    check("jump_idle_pc", 32'(bus.pc), 32'h1);
    push(8'h1C, 4'd1, 4'd2, 1'b0, 1'b0);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;

    // Wrap from the last address
    jump_to(4'd15);
    push(8'h5F, 4'd15, 4'd0, 1'b1, 1'b0);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    check("wrap_pulse", 32'(bus.wrap), 32'h1);
    tick();
    check("wrap_clear", 32'(bus.wrap), 32'h0);
    check("wrap_pc",    32'(bus.pc),   32'h0);

    // Jump beats increment and wrap at the last address
    jump_to(4'd15);
    push(8'h5F, 4'd15, 4'd9, 1'b0, 1'b0);
    bus.run = 1'b1; bus.jump = 1'b1; bus.jump_addr = 4'd9;
    tick();
    bus.jump = 1'b0; bus.run = 1'b0;
    check("jprio_pc",   32'(bus.pc),   32'h9);
    check("jprio_wrap", 32'(bus.wrap), 32'h0);

    // Halt word at address 2, then resume by jump
    load(4'd2, 8'h00);
    jump_to(4'd0);
    push(8'h03, 4'd0, 4'd1, 1'b0, 1'b0);
    push(8'h1C, 4'd1, 4'd2, 1'b0, 1'b0);
    push(8'h00, 4'd2, 4'd2, 1'b0, 1'b1);
    bus.run = 1'b1;
    repeat (5) tick();
    check("halt_halted", 32'(bus.halted),      32'h1);
    check("halt_pc",     32'(bus.pc),          32'h2);
    check("halt_instr",  32'(bus.instr),       32'h0);
    check("halt_addr",   32'(bus.instr_addr),  32'h2);
    check("halt_valid",  32'(bus.instr_valid), 32'h0);
    bus.jump = 1'b1; bus.jump_addr = 4'd5;
    tick();
    bus.jump = 1'b0;
    check("resume_halted", 32'(bus.halted),      32'h0);
    check("resume_valid",  32'(bus.instr_valid), 32'h0);
    check("resume_pc",     32'(bus.pc),          32'h5);
    push(8'h66, 4'd5, 4'd6, 1'b0, 1'b0);
    tick();

    // Asynchronous reset between edges during a run, with a load attempted under reset
    push(8'h55, 4'd6, 4'd7, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pc",     32'(bus.pc),          32'h0);
    check("arst_instr",  32'(bus.instr),       32'h0);
    check("arst_addr",   32'(bus.instr_addr),  32'h0);
    check("arst_valid",  32'(bus.instr_valid), 32'h0);
    check("arst_halted", 32'(bus.halted),      32'h0);
    check("arst_wrap",   32'(bus.wrap),        32'h0);
    bus.run = 1'b0; bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = 8'hAB;
    repeat (2) tick();
    bus.prog_we = 1'b0;
    #2;
    reset = 1'b0;
    push(8'h00, 4'd0, 4'd0, 1'b0, 1'b1);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (3) tick();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_rom_seq.md
PROG_ROM_SEQ -- requirements
Module: prog_rom_seq

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the instruction word width in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter HALT_EN, default 1, SHALL enable halt-word detection when 1 and disable it when 0.
REQ-004 Parameter HALT_WORD, default all-zero DATA_W word, SHALL be the instruction value that halts fetch.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-007 Port run, input, 1, SHALL be the fetch enable; 1 means fetch and advance every cycle.
REQ-008 Port jump, input, 1, SHALL request a PC load from jump_addr.
REQ-009 Port jump_addr, input, ADDR_W, SHALL be the jump target.
REQ-010 Port prog_we, input, 1, SHALL be the program-load write strobe.
REQ-011 Port prog_addr, input, ADDR_W, SHALL be the program-load address.
REQ-012 Port prog_data, input, DATA_W, SHALL be the program-load data.
REQ-013 Port instr, output, DATA_W, SHALL be the registered fetched instruction.
REQ-014 Port instr_addr, output, ADDR_W, SHALL be the address instr was fetched from.
REQ-015 Port instr_valid, output, 1, SHALL be high for exactly the cycles following a fetch edge.
REQ-016 Port pc, output, ADDR_W, SHALL be the current program counter.
REQ-017 Port halted, output, 1, SHALL be high while in state HALTED.
REQ-018 Ports wrap and write_err, output, 1 each, SHALL be the one-cycle event pulses defined below.

Function
REQ-019 The block SHALL have two states: RUN and HALTED.
REQ-020 Fetch edge = rising edge with state RUN and run=1; it SHALL load instr<=mem[pc], instr_addr<=pc and instr_valid<=1.
REQ-021 Fetch latency SHALL be one cycle: instr seen after edge N is the word at the pc value before edge N.
REQ-022 On a fetch edge with jump=0, pc SHALL become pc+1 modulo depth.
REQ-023 On a fetch edge at pc=depth-1 with jump=0, pc SHALL wrap to 0 and wrap SHALL pulse high for one cycle.
REQ-024 jump=1 on any edge SHALL load pc<=jump_addr and force state RUN; jump SHALL take priority over increment, halt detection and wrap (wrap stays 0).
REQ-025 On a fetch edge with HALT_EN=1, jump=0 and mem[pc]==HALT_WORD, the word SHALL still be presented (instr_valid=1), pc SHALL hold and state SHALL become HALTED.
REQ-026 In HALTED without jump, pc, instr and instr_addr SHALL hold and instr_valid SHALL be 0; only jump or reset SHALL leave HALTED.
REQ-027 With run=0 and no jump, pc, instr and instr_addr SHALL hold and instr_valid SHALL be 0.
REQ-028 prog_we=1 with run=0 SHALL write mem[prog_addr]<=prog_data on that edge, visible to fetches from the next edge.
REQ-029 prog_we=1 with run=1 SHALL NOT write memory and SHALL pulse write_err for one cycle.
REQ-030 Memory SHALL be read-only to the fetch path; no other write path SHALL exist.

Reset
REQ-031 reset=1 SHALL immediately set pc=0, instr=0, instr_addr=0, instr_valid=0, halted=0, wrap=0, write_err=0, state=RUN, and clear all memory words to 0.
REQ-032 reset asserted mid-fetch or mid-load SHALL abort it with no partial memory write; first fetch after release SHALL be from address 0.

Verification
REQ-033 Load mem[0..3]=03,1C,4F,2A with run=0, then run=1 for 4 cycles -> instr 03,1C,4F,2A at instr_addr 0..3, instr_valid=1 each, pc=4.
REQ-034 Load mem[15]=5F, jump to 15 then run=1 -> instr=5F, pc=0, wrap=1 for one cycle.
REQ-035 mem[2]=00 (HALT_WORD), run from pc 0 -> instr=00 at instr_addr 2, halted=1, pc holds 2, instr_valid=0 after; jump_addr=5 -> halted=0, next fetch from 5.
REQ-036 run=1 with prog_we=1, prog_addr=1, prog_data=FF -> write_err=1 one cycle, mem[1] unchanged on later fetch.
REQ-037 jump=1, jump_addr=9 at pc=15 with run=1 -> pc=9, wrap=0.
REQ-038 reset pulsed asynchronously between clock edges during run -> all outputs 0 immediately, memory reads 0 after release.
